display_scanner: RTL and testbench

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/display_scanner.sv | 137 +++++++++++++
 tb/tb_display_scanner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
// Four-digit multiplexed 7-segment scanner with hex decode and optional leading-zero blanking.
// Latency: iLoad -> ovDisplayN 2 edges; digit rotation every PRESCALE enabled edges, anode pins one edge after ovCE.
// Backpressure: none; iEnable low freezes the scan (count, select, pins) and suppresses ovCE.
module display_scanner #(
  parameter int unsigned PRESCALE      = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic        iLoad,
  input  logic [15:0] ivValue,
  output logic [3:0]  ovAnodeSel,
  output logic [3:0]  ovAnodePins,
  output logic        ovCE,
  output logic [6:0]  ovDisplay0,
  output logic [6:0]  ovDisplay1,
  output logic [6:0]  ovDisplay2,
  output logic [6:0]  ovDisplay3
);

  localparam logic [19:0] CNT_LAST  = 20'(PRESCALE - 1);
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [6:0]  SEG_ZERO  = 7'h40;
  // Upper digits come out of reset showing what a zero value would decode to.
  localparam logic [6:0]  RST_UPPER = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;

  logic [19:0] cnt_q, cnt_d;
  logic        ce_q, ce_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  pins_q, pins_d;
  logic [15:0] val_q, val_d;
  logic [6:0]  disp0_q, disp0_d;
  logic [6:0]  disp1_q, disp1_d;
  logic [6:0]  disp2_q, disp2_d;
  logic [6:0]  disp3_q, disp3_d;

  // Active-low gfedcba pattern for one hex nibble.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Prescaler, digit rotation and anode pin update.
  always_comb begin
    cnt_d  = cnt_q;
    ce_d   = 1'b0;
    sel_d  = sel_q;
    pins_d = pins_q;
    // Pins pick up the select on the same edge the downstream mux captures it.
    if (ce_q) begin
      pins_d = sel_q;
    end
    if (iEnable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        ce_d  = 1'b1;
        sel_d = {sel_q[2:0], sel_q[3]};
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
  end

  // Value capture and per-digit decode with leading-zero blanking.
  always_comb begin
    val_d   = iLoad ? ivValue : val_q;
    disp0_d = seg_decode(val_q[3:0]);
    disp1_d = seg_decode(val_q[7:4]);
    disp2_d = seg_decode(val_q[11:8]);
    disp3_d = seg_decode(val_q[15:12]);
    if (BLANK_LEADING) begin
      if (val_q[15:12] == 4'h0) disp3_d = SEG_BLANK;
      if (val_q[15:8] == 8'h00) disp2_d = SEG_BLANK;
      if (val_q[15:4] == 12'h000) disp1_d = SEG_BLANK;
    end
  end

  // Scan state registers; select starts on the last digit so the first rotation lands on digit 0.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      cnt_q  <= '0;
      ce_q   <= 1'b0;
      sel_q  <= 4'b0111;
      pins_q <= 4'b1111;
    end else begin
      cnt_q  <= cnt_d;
      ce_q   <= ce_d;
      sel_q  <= sel_d;
      pins_q <= pins_d;
    end
  end

  // Value and segment output registers.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      val_q   <= '0;
      disp0_q <= SEG_ZERO;
      disp1_q <= RST_UPPER;
      disp2_q <= RST_UPPER;
      disp3_q <= RST_UPPER;
    end else begin
      val_q   <= val_d;
      disp0_q <= disp0_d;
      disp1_q <= disp1_d;
      disp2_q <= disp2_d;
      disp3_q <= disp3_d;
    end
  end

  assign ovAnodeSel  = sel_q;
  assign ovAnodePins = pins_q;
  assign ovCE        = ce_q;
  assign ovDisplay0  = disp0_q;
  assign ovDisplay1  = disp1_q;
  assign ovDisplay2  = disp2_q;
  assign ovDisplay3  = disp3_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: three instances (PRESCALE 4/1/3, blanking on/on/off) share stimulus.
// Directed sequences and a vector table cover the boundary cases; a random run is checked against a behavioural model.
module tb_display_scanner;

  logic        clk;
  logic        iReset;
  logic        iEnable;
  logic        iLoad;
  logic [15:0] ivValue;

  logic [3:0] sel_a, pins_a, sel_b, pins_b, sel_c, pins_c;
  logic       ce_a, ce_b, ce_c;
  logic [6:0] a0, a1, a2, a3, b0, b1, b2, b3, c0, c1, c2, c3;
  logic [27:0] disp_a, disp_b, disp_c;
  assign disp_a = {a3, a2, a1, a0};
  assign disp_b = {b3, b2, b1, b0};
  assign disp_c = {c3, c2, c1, c0};

  display_scanner #(.PRESCALE(4), .BLANK_LEADING(1'b1)) dut_a (
    .iClk(clk), .iReset(iReset), .iEnable(iEnable), .iLoad(iLoad), .ivValue(ivValue),
    .ovAnodeSel(sel_a), .ovAnodePins(pins_a), .ovCE(ce_a),
    .ovDisplay0(a0), .ovDisplay1(a1), .ovDisplay2(a2), .ovDisplay3(a3));

  display_scanner #(.PRESCALE(1), .BLANK_LEADING(1'b1)) dut_b (
    .iClk(clk), .iReset(iReset), .iEnable(iEnable), .iLoad(iLoad), .ivValue(ivValue),
    .ovAnodeSel(sel_b), .ovAnodePins(pins_b), .ovCE(ce_b),
    .ovDisplay0(b0), .ovDisplay1(b1), .ovDisplay2(b2), .ovDisplay3(b3));

  display_scanner #(.PRESCALE(3), .BLANK_LEADING(1'b0)) dut_c (
    .iClk(clk), .iReset(iReset), .iEnable(iEnable), .iLoad(iLoad), .ivValue(ivValue),
    .ovAnodeSel(sel_c), .ovAnodePins(pins_c), .ovCE(ce_c),
    .ovDisplay0(c0), .ovDisplay1(c1), .ovDisplay2(c2), .ovDisplay3(c3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  int         p_of[3]     = '{4, 1, 3};
  bit         blank_of[3] = '{1'b1, 1'b1, 1'b0};
  logic [6:0] seg_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          en_edges[3];
  logic        ce_m[3];
  logic [3:0]  sel_m[3];
  logic [3:0]  pins_m[3];
  logic [27:0] disp_m[3];
  logic [15:0] val_m;

  function automatic logic [27:0] expect_disp(input logic [15:0] v, input bit blank);
    logic [6:0] d3, d2, d1, d0;
    d3 = seg_tab[v[15:12]];
    d2 = seg_tab[v[11:8]];
    d1 = seg_tab[v[7:4]];
    d0 = seg_tab[v[3:0]];
    if (blank) begin
      if (v < 16'h1000) d3 = 7'h7F;
      if (v < 16'h0100) d2 = 7'h7F;
      if (v < 16'h0010) d1 = 7'h7F;
    end
    return {d3, d2, d1, d0};
  endfunction

  // Digit k rotations after reset; reset selects digit 3, each rotation advances by one.
  function automatic logic [3:0] sel_of(input int k);
    logic [3:0] s;
    s = 4'hF;
    s[(k + 3) % 4] = 1'b0;
    return s;
  endfunction

  task automatic model_reset();
    val_m = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      en_edges[i] = 0;
      ce_m[i]     = 1'b0;
      sel_m[i]    = sel_of(0);
      pins_m[i]   = 4'hF;
      disp_m[i]   = expect_disp(16'h0000, blank_of[i]);
    end
  endtask

  task automatic model_edge();
    if (iReset) begin
      model_reset();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ce_m[i]) pins_m[i] = sel_m[i];
        ce_m[i] = 1'b0;
        if (iEnable) begin
          en_edges[i]++;
          if (en_edges[i] % p_of[i] == 0) ce_m[i] = 1'b1;
          sel_m[i] = sel_of(en_edges[i] / p_of[i]);
        end
        disp_m[i] = expect_disp(val_m, blank_of[i]);
      end
      if (iLoad) val_m = ivValue;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(input int i, input string tag, input logic ce, input logic [3:0] sel,
                            input logic [3:0] pins, input logic [27:0] disp);
    chk({tag, "_ce"}, {31'd0, ce}, {31'd0, ce_m[i]});
    chk({tag, "_sel"}, {28'd0, sel}, {28'd0, sel_m[i]});
    chk({tag, "_pins"}, {28'd0, pins}, {28'd0, pins_m[i]});
    chk({tag, "_disp"}, {4'd0, disp}, {4'd0, disp_m[i]});
  endtask

  task automatic check_all();
    check_inst(0, "a", ce_a, sel_a, pins_a, disp_a);
    check_inst(1, "b", ce_b, sel_b, pins_b, disp_b);
    check_inst(2, "c", ce_c, sel_c, pins_c, disp_c);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
    check_all();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] value;
    logic [27:0] exp_blank;
    logic [27:0] exp_noblank;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rot_seq[5];
    logic       seen;
    rot_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    vecs[0] = '{16'h00A5, {7'h7F, 7'h7F, 7'h08, 7'h12}, {7'h40, 7'h40, 7'h08, 7'h12}};
    vecs[1] = '{16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[2] = '{16'hF0F0, {7'h0E, 7'h40, 7'h0E, 7'h40}, {7'h0E, 7'h40, 7'h0E, 7'h40}};
    vecs[3] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[4] = '{16'h0089, {7'h7F, 7'h7F, 7'h00, 7'h10}, {7'h40, 7'h40, 7'h00, 7'h10}};
    vecs[5] = '{16'h0C0D, {7'h7F, 7'h46, 7'h40, 7'h21}, {7'h40, 7'h46, 7'h40, 7'h21}};
    vecs[6] = '{16'hBEEF, {7'h03, 7'h06, 7'h06, 7'h0E}, {7'h03, 7'h06, 7'h06, 7'h0E}};
    vecs[7] = '{16'h0007, {7'h7F, 7'h7F, 7'h7F, 7'h78}, {7'h40, 7'h40, 7'h40, 7'h78}};

    iReset  = 1'b1;
    iEnable = 1'b0;
    iLoad   = 1'b0;
    ivValue = 16'h0000;
    model_reset();

    // Reset state.
    @(posedge clk);
    #2;
    chk("rst_ce_a", {31'd0, ce_a}, 32'd0);
    chk("rst_sel_a", {28'd0, sel_a}, 32'h7);
    chk("rst_pins_a", {28'd0, pins_a}, 32'hF);
    chk("rst_disp_a", {4'd0, disp_a}, {4'd0, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    chk("rst_disp_c", {4'd0, disp_c}, {4'd0, 7'h40, 7'h40, 7'h40, 7'h40});
    iReset  = 1'b0;
    iEnable = 1'b1;

    // Scan startup with PRESCALE=4: strobe every 4th edge, pins one edge behind.
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("scan_ce_a", {31'd0, ce_a}, (i % 4 == 0) ? 32'd1 : 32'd0);
      if (i % 4 == 0) chk("scan_sel_a", {28'd0, sel_a}, {28'd0, rot_seq[i / 4 - 1]});
      if (i <= 4) chk("scan_pins_idle_a", {28'd0, pins_a}, 32'hF);
      if (i == 5) chk("scan_pins_first_a", {28'd0, pins_a}, 32'hE);
    end

    // Enable dropped with count at 2: everything freezes, then ovCE two edges after re-enable.
    step();
    step();
    iEnable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_ce_a", {31'd0, ce_a}, 32'd0);
      chk("hold_sel_a", {28'd0, sel_a}, 32'hE);
      chk("hold_pins_a", {28'd0, pins_a}, 32'hE);
    end
    iEnable = 1'b1;
    step();
    chk("resume1_ce_a", {31'd0, ce_a}, 32'd0);
    step();
    chk("resume2_ce_a", {31'd0, ce_a}, 32'd1);
    chk("resume2_sel_a", {28'd0, sel_a}, 32'hD);

    // Display vectors: load, then visible two edges after the load sample.
    for (int v = 0; v < 8; v++) begin
      iLoad   = 1'b1;
      ivValue = vecs[v].value;
      step();
      iLoad = 1'b0;
      step();
      chk("vec_disp_blank", {4'd0, disp_a}, {4'd0, vecs[v].exp_blank});
      chk("vec_disp_noblank", {4'd0, disp_c}, {4'd0, vecs[v].exp_noblank});
    end

    // Reset during an ovCE cycle, then PRESCALE=1 strobes continuously.
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (ce_a) seen = 1'b1;
    end
    chk("ce_wait_a", {31'd0, seen}, 32'd1);
    iLoad   = 1'b1;
    ivValue = 16'h4321;
    iReset  = 1'b1;
    #1;
    model_reset();
    chk("midrst_ce_a", {31'd0, ce_a}, 32'd0);
    chk("midrst_pins_a", {28'd0, pins_a}, 32'hF);
    chk("midrst_sel_a", {28'd0, sel_a}, 32'h7);
    chk("midrst_ce_b", {31'd0, ce_b}, 32'd0);
    check_all();
    step();
    iReset = 1'b0;
    iLoad  = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("p1_ce_b", {31'd0, ce_b}, 32'd1);
      chk("p1_sel_b", {28'd0, sel_b}, {28'd0, rot_seq[(j - 1) % 4]});
    end

    // Randomized run against the model, with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      iEnable = ($urandom % 8) != 0;
      iLoad   = ($urandom % 4) == 0;
      case ($urandom % 4)
        0: ivValue = 16'($urandom);
        1: ivValue = 16'($urandom) & 16'h00FF;
        2: ivValue = 16'($urandom) & 16'h000F;
        default: ivValue = 16'($urandom) & 16'h0FFF;
      endcase
      if ($urandom % 300 == 0) begin
        iReset = 1'b1;
        #1;
        model_reset();
        check_all();
        step();
        iReset = 1'b0;
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
